// File: rtl/radix4_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
// RADIX4_SIGNED_EN selects two's-complement operands; undefined gives unsigned operands.
package radix4_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_t;

    // Unsigned operands need one extra digit to absorb the zero-extended top bits.
    function automatic int unsigned ndig(input int unsigned width);
`ifdef RADIX4_SIGNED_EN
        return width / 2;
`else
        return width / 2 + 1;
`endif
    endfunction

    function automatic booth_t booth_enc(input logic [2:0] triple);
        booth_t d;
        case (triple)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/radix4_pp_sel.sv
// Booth partial-product selector: maps a digit triple and the (WIDTH+1)-bit
// multiplicand to a sign-extended 2*WIDTH-bit partial product.
module radix4_pp_sel
    import radix4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]         triple,
    input  logic [WIDTH:0]     xe,
    output logic [2*WIDTH-1:0] pp
);

    logic [2*WIDTH-1:0] xs;

    assign xs = {{(WIDTH - 1){xe[WIDTH]}}, xe};

    always_comb begin
        pp = '0;
        unique case (booth_enc(triple))
            ZERO:    pp = '0;
            P1:      pp = xs;
            P2:      pp = xs << 1;
            M1:      pp = -xs;
            M2:      pp = -(xs << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/radix4_seq_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define RADIX4_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module radix4_seq_mul
    import radix4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int unsigned NDIG = ndig(WIDTH);
    localparam int unsigned CW   = $clog2(NDIG + 1);
    localparam int unsigned YW   = WIDTH + 3;

    state_t             state_q, state_d;
    logic [WIDTH:0]     xe_q, xe_d;
    logic [YW-1:0]      ym_q, ym_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pp;
    logic               ext_x, ext_y;

`ifdef RADIX4_SIGNED_EN
    assign ext_x = x[WIDTH-1];
    assign ext_y = y[WIDTH-1];
`else
    assign ext_x = 1'b0;
    assign ext_y = 1'b0;
`endif

    radix4_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .triple (ym_q[2:0]),
        .xe     (xe_q),
        .pp     (pp)
    );

    always_comb begin
        state_d = state_q;
        xe_d    = xe_q;
        ym_d    = ym_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xe_d    = {ext_x, x};
                    // Appended zero is y[-1]; the low three bits always hold the current triple.
                    ym_d    = {ext_y, ext_y, y, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + (pp << {cnt_q, 1'b0});
                ym_d  = ym_q >> 2;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xe_q    <= '0;
            ym_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xe_q    <= xe_d;
            ym_q    <= ym_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = !in_ready;
    assign p         = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_radix4_seq_mul.sv
// Directed and random checks for radix4_seq_mul at WIDTH=8.
// Expected values follow RADIX4_SIGNED_EN the same way the design does.
module tb_radix4_seq_mul;

    localparam int W = 8;
`ifdef RADIX4_SIGNED_EN
    localparam int NDIG = W / 2;
`else
    localparam int NDIG = W / 2 + 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] p;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    radix4_seq_mul #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ae, be;
`ifdef RADIX4_SIGNED_EN
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
`else
        ae = {{W{1'b0}}, a};
        be = {{W{1'b0}}, b};
`endif
        return ae * be;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, " idle"}, in_ready, 1);
        x = a;
        y = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, " calc p"}, p, 0);
        chk({tag, " calc busy"}, busy, 1);
        n = 1;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk({tag, " latency"}, n, NDIG + 1);
        chk({tag, " p"}, p, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " drained"}, out_valid, 0);
    endtask

    initial begin
        int n;
        int seen;
        int prev;
        int acc_cyc;
        logic [W-1:0]   bx [4];
        logic [W-1:0]   by [4];
        logic [2*W-1:0] bp [4];
        logic [W-1:0]   ra, rb;

        // Reset state.
        step();
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst p", p, 0);
        rst_n = 1'b1;
        step();

        // Extreme operands.
        run_op(8'h80, 8'h80, 16'h4000, "min*min");
`ifdef RADIX4_SIGNED_EN
        run_op(8'hFF, 8'hFF, 16'h0001, "m1*m1");
        run_op(8'hFF, 8'h01, 16'hFFFF, "m1*1");
`else
        run_op(8'hFF, 8'hFF, 16'hFE01, "255*255");
        run_op(8'hFF, 8'h01, 16'h00FF, "255*1");
`endif
        run_op(8'h00, 8'hB3, 16'h0000, "0*y");

        // Held output with an ignored offer during the wait.
        x = 8'd7;
        y = 8'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("hold latency", n, NDIG + 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                x = 8'd1;
                y = 8'd1;
                in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            chk("hold p", p, 16'd21);
            chk("hold in_ready", in_ready, 0);
            chk("hold out_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold released", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy || out_valid) seen = 1;
        end
        chk("ignored offer", seen, 0);

        // Reset in the middle of a calculation.
        x = 8'd15;
        y = 8'd15;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst p", p, 0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("midrst no result", seen, 0);
        run_op(8'd15, 8'd15, 16'd225, "after rst");

        // Back-to-back with both handshakes held high.
        bx[0] = 8'd3;   by[0] = 8'd5;   bp[0] = 16'd15;
        bx[1] = 8'd100; by[1] = 8'd2;   bp[1] = 16'd200;
        bx[2] = 8'd12;  by[2] = 8'd12;  bp[2] = 16'd144;
        bx[3] = 8'd9;   by[3] = 8'd100; bp[3] = 16'h0384;
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            x = bx[k];
            y = by[k];
            n = 0;
            while (!in_ready && n < 20) begin
                step();
                n++;
            end
            acc_cyc = cyc;
            if (k > 0) chk("b2b interval", acc_cyc - prev, NDIG + 2);
            prev = acc_cyc;
            step();
            n = 1;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            if (k == 3) in_valid = 1'b0;
            chk("b2b p", p, bp[k]);
        end
        step();
        out_ready = 1'b0;
        chk("b2b idle", in_ready, 1);

        // Random pairs against the reference product.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, ref_mul(ra, rb), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/radix4_seq_mul.md
RADIX4_SEQ_MUL -- requirements
Module: radix4_seq_mul

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (even, >= 4); the product is 2*WIDTH bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: x  input  WIDTH  multiplicand.
REQ-008 Port: y  input  WIDTH  multiplier; Booth-recoded.
REQ-009 Port: out_valid  output  1  product available.
REQ-010 Port: out_ready  input  1  consumer takes product.
REQ-011 Port: p  output  2*WIDTH  product.
REQ-012 Port: busy  output  1  high in CALC or DONE.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = !in_ready.
REQ-014 IDLE: on in_valid && in_ready, latch x and y, clear the 2*WIDTH accumulator, clear the digit counter, and go to CALC; otherwise stay in IDLE.
REQ-015 CALC: each cycle, take Booth digit i from {y[2i+1], y[2i], y[2i-1]} (y[-1]=0), map it to a partial product in {0, +X, +2X, -X, -2X}, sign-extend it to 2*WIDTH, shift it left by 2i, add it to the accumulator modulo 2^(2*WIDTH), and increment i.
REQ-016 CALC SHALL last NDIG cycles, then go to DONE; the cycle from the accept edge to out_valid high is NDIG+1.
REQ-017 DONE: p holds the accumulator; out_valid stays high and p stays stable until out_ready; on out_valid && out_ready, go to IDLE.
REQ-018 in_valid while busy SHALL be ignored, with no effect on the state or the latched operands; a new pair is accepted no earlier than the cycle after the DONE handshake.
REQ-019 p SHALL read 0 in IDLE and CALC; it is valid only while out_valid is high.
REQ-020 out_ready in IDLE or CALC SHALL be ignored.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE and clear the accumulator, the counter and the operand registers, giving in_ready=1, out_valid=0, busy=0, p=0.
REQ-022 A reset during CALC or DONE SHALL discard the operation; no out_valid pulse follows.
REQ-023 Release of reset SHALL take effect at the first rising clk edge with rst_n high.

Configuration
REQ-024 With RADIX4_SIGNED_EN defined, x, y and p SHALL be two's complement, the multiplier extension is a sign extension, and NDIG = WIDTH/2.
REQ-025 Without RADIX4_SIGNED_EN, x, y and p SHALL be unsigned; y is zero-extended by 2 bits, x is treated as a positive (WIDTH+1)-bit value, and NDIG = WIDTH/2+1.

Structure
REQ-026 Package radix4_pkg SHALL hold the state enum, the Booth digit encoding (ZERO, P1, P2, M1, M2) and the NDIG derivation function.
REQ-027 The combinational sub-module radix4_pp_sel SHALL map (digit triple, X) to a sign-extended partial product; everything else stays in radix4_seq_mul.

Verification
REQ-028 The bench SHALL cover each scenario below with WIDTH=8.
REQ-029 Signed, x=-128, y=-128 -> p=16384 (0x4000) with out_valid on cycle 5 after the accept.
REQ-030 Unsigned, x=255, y=255 -> p=65025 (0xFE01) with out_valid on cycle 6 after the accept.
REQ-031 x=7, y=3, out_ready held low for 10 cycles -> p=21 stable throughout, in_ready=0, and a second in_valid with x=1, y=1 during the wait is ignored.
REQ-032 Assert rst_n low for 1 cycle at CALC cycle 2 with x=15, y=15 -> no out_valid; the next operation x=15, y=15 returns p=225.
REQ-033 Signed, x=-1, y=1 -> p=0xFFFF; x=0, y=-77 -> p=0; 1000 random pairs SHALL match a reference product.
REQ-034 Back-to-back: out_ready tied high and in_valid held high -> one accept every NDIG+2 cycles, with products in order.
